// File: rtl/ps2_kbd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_ctrl_if
// Description : Byte-in / event-out handshake bundle for the PS/2 keyboard
//               protocol controller. The slave modport is the controller side.
//               The master modport is the side that supplies bytes and
//               consumes events.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kbd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;

    modport master (
        output rx_data, rx_valid, ev_ready,
        input  ev_valid, ev_data
    );

    modport slave (
        input  rx_data, rx_valid, ev_ready,
        output ev_valid, ev_data
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_ctrl
// Description : Set-2 scancode decoder (E0 extended / F0 break prefixes).
//               Decoded key events go into a first-word-fall-through event
//               FIFO that the consumer drains over a valid/ready handshake.
//               The module also tracks the held key, a press counter and a
//               sticky overflow flag.
//               Optional macro KBD_REPEAT_FILTER_EN: drops typematic repeats
//               of the currently held key.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_ctrl #(
    parameter int          DEPTH   = 8,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    ps2_kbd_ctrl_if.slave                   kbd,
    output logic [$clog2(DEPTH+1)-1:0]      o_fifo_count,
    output logic                            o_overflow,
    input  wire logic                       i_ovf_clr,
    output logic                            o_key_down,
    output logic [8:0]                      o_last_key,
    output logic [7:0]                      o_press_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_to_cnt;
    logic        w_emit;
    logic        w_ext;
    logic        w_brk;
    logic        w_is_repeat;
    logic        w_push;
    logic        w_rd;
    logic        w_wr;
    logic        w_full;
    logic [9:0]  w_ev;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_key_down;
    logic [8:0]    r_last_key;
    logic [7:0]    r_press_cnt;

    // Decoder state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Prefix timeout counter: runs only while a prefix is pending and no byte arrives
    always_ff @(posedge clk) begin
        if (reset || kbd.rx_valid || r_state == ST_IDLE) r_to_cnt <= 20'd0;
        else                                             r_to_cnt <= r_to_cnt + 20'd1;
    end

    // Next-state and event decode for one incoming byte
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ext       = 1'b0;
        w_brk       = 1'b0;
        if (kbd.rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (kbd.rx_data == 8'hE0)      w_state_nxt = ST_EXT;
                    else if (kbd.rx_data == 8'hF0) w_state_nxt = ST_BRK;
                    else if (kbd.rx_data == 8'h00 || kbd.rx_data == 8'hFF ||
                             kbd.rx_data == 8'hAA || kbd.rx_data == 8'hEE ||
                             kbd.rx_data == 8'hFA || kbd.rx_data == 8'hFE) begin
                        // Controller responses and error codes carry no key event
                        w_state_nxt = ST_IDLE;
                    end
                    else w_emit = 1'b1;
                end
                ST_EXT: begin
                    if (kbd.rx_data == 8'hF0)      w_state_nxt = ST_EXT_BRK;
                    else if (kbd.rx_data != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (kbd.rx_data != 8'hF0 && kbd.rx_data != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_brk       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    if (kbd.rx_data != 8'hF0 && kbd.rx_data != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_ext       = 1'b1;
                        w_brk       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
        else if (r_state != ST_IDLE && r_to_cnt == TIMEOUT - 20'd1) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_ev = {w_ext, w_brk, kbd.rx_data};

`ifdef KBD_REPEAT_FILTER_EN
    // A make of the key already held down is a typematic repeat
    assign w_is_repeat = w_emit && !w_brk && r_key_down &&
                         ({w_ext, kbd.rx_data} == r_last_key);
`else
    assign w_is_repeat = 1'b0;
`endif

    assign w_push = w_emit && !w_is_repeat;
    assign w_full = (r_count == CW'(DEPTH));
    assign w_rd   = kbd.ev_ready && (r_count != '0);
    // A push into a full FIFO still lands if the head leaves in the same cycle
    assign w_wr   = w_push && (!w_full || w_rd);

    // Event storage, cleared so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 10'd0;
        end
        else if (w_wr) begin
            r_mem[r_wr_ptr] <= w_ev;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end
        else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
        end
    end

    // Sticky overflow; an explicit clear beats a same-cycle drop
    always_ff @(posedge clk) begin
        if (reset || i_ovf_clr)              r_overflow <= 1'b0;
        else if (w_push && w_full && !w_rd)  r_overflow <= 1'b1;
    end

    // Held-key tracking follows only events that made it into the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_down  <= 1'b0;
            r_last_key  <= 9'd0;
            r_press_cnt <= 8'd0;
        end
        else if (w_wr) begin
            if (!w_brk) begin
                r_last_key  <= {w_ext, kbd.rx_data};
                r_key_down  <= 1'b1;
                r_press_cnt <= r_press_cnt + 8'd1;
            end
            else if ({w_ext, kbd.rx_data} == r_last_key) begin
                r_key_down <= 1'b0;
            end
        end
    end

    assign kbd.ev_valid = (r_count != '0);
    assign kbd.ev_data  = r_mem[r_rd_ptr];
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_key_down   = r_key_down;
    assign o_last_key   = r_last_key;
    assign o_press_cnt  = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_ctrl
// Description : Directed self-checking bench for ps2_kbd_ctrl (DEPTH=8,
//               short TIMEOUT). Expected values follow KBD_REPEAT_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_ctrl;

    localparam int          DEPTH   = 8;
    localparam logic [19:0] TIMEOUT = 20'd16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ovf_clr;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       key_down;
    logic [8:0] last_key;
    logic [7:0] press_cnt;
    int         checks = 0;
    int         failures = 0;

    ps2_kbd_ctrl_if bus ();

    ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .kbd          (bus.slave),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow),
        .i_ovf_clr    (ovf_clr),
        .o_key_down   (key_down),
        .o_last_key   (last_key),
        .o_press_cnt  (press_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [9:0] exp);
        chk({tag, "_valid"}, {31'd0, bus.ev_valid}, 32'd1);
        chk({tag, "_data"}, {22'd0, bus.ev_data}, {22'd0, exp});
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        ovf_clr      = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.ev_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ev_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("rst_ev_data",  {22'd0, bus.ev_data},  32'd0);
        chk("rst_count",    {28'd0, fifo_count},   32'd0);
        chk("rst_overflow", {31'd0, overflow},     32'd0);
        chk("rst_key_down", {31'd0, key_down},     32'd0);
        chk("rst_last_key", {23'd0, last_key},     32'd0);
        chk("rst_press",    {24'd0, press_cnt},    32'd0);

        // Plain make then break with consumer always ready
        bus.ev_ready = 1'b1;
        bus.rx_data  = 8'h1C;
        bus.rx_valid = 1'b1;
        #3;
        chk("t1_no_bypass", {31'd0, bus.ev_valid}, 32'd0);
        tick();
        bus.rx_valid = 1'b0;
        chk("t1_make_valid", {31'd0, bus.ev_valid}, 32'd1);
        chk("t1_make_data",  {22'd0, bus.ev_data},  32'h01C);
        chk("t1_key_down1",  {31'd0, key_down},     32'd1);
        chk("t1_press",      {24'd0, press_cnt},    32'd1);
        send(8'hF0);
        chk("t1_popped", {31'd0, bus.ev_valid}, 32'd0);
        send(8'h1C);
        chk("t1_brk_valid", {31'd0, bus.ev_valid}, 32'd1);
        chk("t1_brk_data",  {22'd0, bus.ev_data},  32'h11C);
        chk("t1_key_down0", {31'd0, key_down},     32'd0);
        tick();
        bus.ev_ready = 1'b0;
        chk("t1_empty", {28'd0, fifo_count}, 32'd0);

        // Extended make and extended break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("t2_count",    {28'd0, fifo_count}, 32'd2);
        chk("t2_last_key", {23'd0, last_key},   32'h175);
        chk("t2_key_down", {31'd0, key_down},   32'd0);
        chk("t2_press",    {24'd0, press_cnt},  32'd2);
        pop("t2_ev0", 10'h275);
        pop("t2_ev1", 10'h375);

        // Fill past capacity: ninth make is dropped and leaves key state alone
        for (int i = 0; i <= DEPTH; i++) send(8'h1C + 8'(i));
        chk("t3_count",    {28'd0, fifo_count}, 32'd8);
        chk("t3_overflow", {31'd0, overflow},   32'd1);
        chk("t3_press",    {24'd0, press_cnt},  32'd10);
        chk("t3_last_key", {23'd0, last_key},   32'h023);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);

        // Clear wins over a drop in the same cycle
        ovf_clr = 1'b1;
        send(8'h40);
        ovf_clr = 1'b0;
        chk("t4_clr_prio", {31'd0, overflow},   32'd0);
        chk("t4_cnt_drop", {28'd0, fifo_count}, 32'd8);
        chk("t4_prs_drop", {24'd0, press_cnt},  32'd10);

        // Push and pop together while full
        bus.ev_ready = 1'b1;
        send(8'h30);
        bus.ev_ready = 1'b0;
        chk("t4_ovf",   {31'd0, overflow},   32'd0);
        chk("t4_count", {28'd0, fifo_count}, 32'd8);
        chk("t4_head",  {22'd0, bus.ev_data}, 32'h01D);
        chk("t4_press", {24'd0, press_cnt},  32'd11);
        chk("t4_last",  {23'd0, last_key},   32'h030);
        pop("t4_d0", 10'h01D); pop("t4_d1", 10'h01E); pop("t4_d2", 10'h01F);
        pop("t4_d3", 10'h020); pop("t4_d4", 10'h021); pop("t4_d5", 10'h022);
        pop("t4_d6", 10'h023); pop("t4_d7", 10'h030);
        chk("t4_drained", {28'd0, fifo_count}, 32'd0);

        // Abandoned E0 prefix, then a plain make
        send(8'hE0);
        repeat (int'(TIMEOUT) + 2) tick();
        send(8'h1C);
        chk("t5_to_count", {28'd0, fifo_count}, 32'd1);
        pop("t5_to_ev", 10'h01C);
        // Prefix that completes well before the timeout stays extended
        send(8'hE0);
        repeat (5) tick();
        send(8'h75);
        pop("t5_ext_ev", 10'h275);
        // Controller response byte produces nothing
        send(8'hAA);
        tick();
        chk("t5_aa_count", {28'd0, fifo_count}, 32'd0);
        chk("t5_press",    {24'd0, press_cnt},  32'd13);

        // Typematic repeat of one key
        send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
        chk("t6_count", {28'd0, fifo_count}, 32'd1);
        chk("t6_press", {24'd0, press_cnt},  32'd14);
`else
        chk("t6_count", {28'd0, fifo_count}, 32'd3);
        chk("t6_press", {24'd0, press_cnt},  32'd16);
`endif
        chk("t6_last", {23'd0, last_key}, 32'h01C);

        // Reset with events queued and a prefix pending
        send(8'hF0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_count", {28'd0, fifo_count},   32'd0);
        chk("t7_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("t7_press", {24'd0, press_cnt},    32'd0);
        chk("t7_kdown", {31'd0, key_down},     32'd0);
        send(8'h1C);
        pop("t7_fresh", 10'h01C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Keyboard protocol controller that sits downstream of the PS/2 byte receiver. It consumes raw scancode bytes and decodes the set-2 prefix sequences (E0 extended, F0 break) into single key events. Events are queued in an internal FIFO and handed to the consumer (CPU MMIO shim or display logic) over a valid/ready interface. It also tracks the held key, a press counter and a sticky overflow flag.

Parameters:
DEPTH, 8, event FIFO depth in entries; power of two, minimum 2
TIMEOUT, 20'd1000000, clk cycles allowed between a prefix byte and its code byte before the decoder abandons the sequence

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  scancode byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
ev_valid  out  1  FIFO head holds an event
ev_data  out  10  {ext, brk, code[7:0]} at FIFO head
ev_ready  in  1  consumer accepts head when ev_valid&ev_ready
fifo_count  out  $clog2(DEPTH+1)  number of queued events
overflow  out  1  sticky; an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow; ovf_clr takes precedence over a same-cycle set
key_down  out  1  last made key has not been released
last_key  out  9  {ext, code} of the most recent make event
press_cnt  out  8  count of make events written to the FIFO, wraps 255->0

Behaviour:
- Reset: decoder state IDLE, FIFO empty, ev_valid=0, ev_data=0, fifo_count=0, overflow=0, key_down=0, last_key=0, press_cnt=0, timeout counter=0.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. It advances only on cycles with rx_valid=1.
- IDLE: E0->EXT; F0->BRK; 00, FF, AA, EE, FA, FE are discarded with no event and no state change; any other byte emits make {0,0,code}.
- EXT: F0->EXT_BRK; E0 stays EXT; any other byte emits {1,0,code} and returns to IDLE.
- BRK: F0/E0 stay BRK; any other byte emits {0,1,code} and returns to IDLE.
- EXT_BRK: F0/E0 stay EXT_BRK; any other byte emits {1,1,code} and returns to IDLE.
- Timeout: in any non-IDLE state, the counter increments every cycle without rx_valid. On reaching TIMEOUT-1, the FSM goes to IDLE with no event. The counter clears on rx_valid and whenever the state is IDLE.
- Latency: an event is written at the clock edge ending the rx_valid cycle. ev_valid rises the next cycle if the FIFO was empty. There is no combinational bypass.
- FIFO: first-word-fall-through. ev_data = mem[rd_ptr], pointers wrap modulo DEPTH.
- Pop when ev_valid&ev_ready.
- Push while full without a same-cycle pop: the event is dropped and overflow is set.
- Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
- Push and pop in the same cycle while empty: the pop is ignored (ev_valid=0) and the push lands.
- key_down, last_key, press_cnt:
  - On an accepted make: last_key={ext,code}, key_down=1, press_cnt+1.
  - On any break matching last_key: key_down=0.
  - Dropped events update none of these.
- Reset mid-sequence or mid-FIFO: everything returns to reset values; queued events are lost.

Optional Feature:
KBD_REPEAT_FILTER_EN: when defined, a make whose {ext,code} equals last_key while key_down=1 is treated as typematic repeat. It is discarded: no FIFO write, press_cnt unchanged, FSM returns to IDLE. When undefined, every make is queued and counted.

Test Plan:
- Bytes 1C, F0, 1C, ev_ready=1 -> events 0x01C then 0x11C; press_cnt=1; key_down 1 then 0; ev_valid first high one cycle after the 1C strobe.
- Bytes E0, 75, E0, F0, 75 -> events 0x275 then 0x375; last_key=0x175.
- ev_ready=0 with DEPTH+1 make bytes 1C..(1C+DEPTH) -> fifo_count=DEPTH; overflow=1; press_cnt=DEPTH; draining returns the first DEPTH codes in order; ovf_clr pulse -> overflow=0.
- FIFO full, push with ev_ready=1 in the same cycle -> no overflow, count stays DEPTH, head advances.
- Byte E0 then no bytes for TIMEOUT cycles, then 1C -> single event 0x01C (ext=0). Byte AA in IDLE -> no event.
- Three makes of 1C with no break: with KBD_REPEAT_FILTER_EN -> one event, press_cnt=1; without it -> three events, press_cnt=3.
